// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared chiplet link types, header layout and CRC-32 constants
package chiplet_types_pkg;

  typedef logic [4:0] node_id_t;

  localparam logic [3:0]  FMT_RESP   = 4'h2;
  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [3:0] fmt;
    node_id_t   dest;
    node_id_t   src;
    logic       err;
    logic [6:0] len;
    logic [9:0] rsvd;
  } resp_hdr_t;

endpackage

// File: rtl/crc32_word.sv
// rtl/crc32_word.sv - combinational CRC-32 update over one 32-bit word, MSB first
module crc32_word
  import chiplet_types_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] word,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (next_crc[31] ^ word[i])
        next_crc = {next_crc[30:0], 1'b0} ^ CRC32_POLY;
      else
        next_crc = {next_crc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/resp_packer.sv
// rtl/resp_packer.sv - response packetizer: header, pass-through data words, CRC trailer
module resp_packer
  import chiplet_types_pkg::*;
#(
  parameter node_id_t NODE_ID   = 5'd0,
  parameter int       MAX_WORDS = 64,
  localparam int      LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             fifo_empty,
  input  logic [4:0]       fifo_rdata,
  output logic             fifo_ren,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_data,
  input  logic [LEN_W-1:0] rsp_len,
  input  logic             rsp_err,
  input  logic             rsp_last,
  output logic             flit_valid,
  input  logic             flit_ready,
  output logic [31:0]      flit_data,
  output logic             flit_last,
  output logic             len_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CRC  = 2'd3;

  logic [1:0]       state;
  node_id_t         dest_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [LEN_W-1:0] count;
  logic [31:0]      crc_q;
  logic [31:0]      crc_next;
  logic [31:0]      crc_word;
  resp_hdr_t        hdr;
  logic             final_beat;

  always_comb begin
    hdr.fmt  = FMT_RESP;
    hdr.dest = dest_q;
    hdr.src  = NODE_ID;
    hdr.err  = err_q;
    hdr.len  = 7'(len_q);
    hdr.rsvd = 10'b0;
  end

  assign final_beat = (count == len_q - LEN_W'(1));
  assign crc_word   = (state == ST_HDR) ? hdr : rsp_data;

  crc32_word u_crc (
    .crc_in   (crc_q),
    .word     (crc_word),
    .next_crc (crc_next)
  );

  // Data beats are a straight wire from the response side to the flit side.
  always_comb begin
    fifo_ren   = 1'b0;
    rsp_ready  = 1'b0;
    flit_valid = 1'b0;
    flit_last  = 1'b0;
    flit_data  = 32'h0;
    case (state)
      ST_IDLE: fifo_ren = !fifo_empty && rsp_valid;
      ST_HDR: begin
        flit_valid = 1'b1;
        flit_data  = hdr;
      end
      ST_DATA: begin
        flit_valid = rsp_valid;
        rsp_ready  = flit_ready;
        flit_data  = rsp_data;
      end
      default: begin
        flit_valid = 1'b1;
        flit_last  = 1'b1;
        flit_data  = ~crc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      count   <= '0;
      crc_q   <= CRC32_INIT;
      len_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_ren) begin
            dest_q <= fifo_rdata;
            err_q  <= rsp_err;
            // A zero-length response is still framed as one word so the requestor gets an answer.
            if (rsp_len == '0) begin
              len_q   <= LEN_W'(1);
              len_err <= 1'b1;
            end else begin
              len_q <= rsp_len;
            end
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (flit_ready) begin
            crc_q <= crc_next;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rsp_valid && flit_ready) begin
            crc_q <= crc_next;
            if (rsp_last != final_beat)
              len_err <= 1'b1;
            if (final_beat) begin
              count <= '0;
              state <= ST_CRC;
            end else begin
              count <= count + LEN_W'(1);
            end
          end
        end
        default: begin
          if (flit_ready) begin
            crc_q <= CRC32_INIT;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_packer.sv
// tb/tb_resp_packer.sv - scoreboard bench for resp_packer with directed packets
module tb_resp_packer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        fifo_empty;
  logic [4:0]  fifo_rdata;
  logic        fifo_ren;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [6:0]  rsp_len;
  logic        rsp_err;
  logic        rsp_last;
  logic        flit_valid;
  logic        flit_ready;
  logic [31:0] flit_data;
  logic        flit_last;
  logic        len_err;

  always #5 clk = ~clk;

  resp_packer #(.NODE_ID(5'd3), .MAX_WORDS(64)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_len    (rsp_len),
    .rsp_err    (rsp_err),
    .rsp_last   (rsp_last),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .flit_last  (flit_last),
    .len_err    (len_err)
  );

  int          total = 0;
  int          bad = 0;
  int          ren_cnt = 0;
  int          hs_cnt = 0;
  logic [32:0] exp_q[$];
  logic [4:0]  id_q[$];
  bit          rand_ready = 1'b0;
  bit          abort = 1'b0;
  bit          sending = 1'b0;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c ^ w;
    for (int i = 0; i < 32; i++)
      r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic void upd_fifo();
    fifo_empty = (id_q.size() == 0);
    fifo_rdata = fifo_empty ? 5'h0 : id_q[0];
  endfunction

  task automatic push_id(input logic [4:0] id);
    id_q.push_back(id);
    upd_fifo();
  endtask

  // Requestor-ID FIFO model: pop after the edge on which the DUT asserted fifo_ren.
  initial begin
    bit          ren_s;
    logic [4:0]  tmp;
    forever begin
      @(negedge clk);
      ren_s = fifo_ren && n_rst;
      @(posedge clk);
      #1;
      if (ren_s && id_q.size() > 0) begin
        ren_cnt++;
        tmp = id_q.pop_front();
      end
      upd_fifo();
    end
  end

  initial begin
    flit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      flit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops on every flit handshake, plus hold-while-stalled checks.
  initial begin
    bit          stall;
    logic [31:0] sdata;
    logic [32:0] e;
    stall = 1'b0;
    sdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", 64'(flit_valid), 64'(1));
          check("stall_data", 64'(flit_data), 64'(sdata));
        end
        if (flit_valid && flit_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL flit_unexpected: got %h want none", flit_data);
          end else begin
            e = exp_q.pop_front();
            check("flit", 64'({flit_last, flit_data}), 64'(e));
          end
        end
        stall = flit_valid && !flit_ready;
        sdata = flit_data;
      end
    end
  end

  task automatic send(input logic [6:0] len_in, input bit err, input logic [31:0] hdr,
                      input logic [31:0] base, input logic [7:0] last_mask, input int nw);
    logic [31:0] c;
    bit          hs;
    int          guard;
    sending = 1'b1;
    c = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, hdr});
    c = crc_step(c, hdr);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({1'b0, base + 32'(i) * 32'h0101_0101});
      c = crc_step(c, base + 32'(i) * 32'h0101_0101);
    end
    exp_q.push_back({1'b1, ~c});
    rsp_len = len_in;
    rsp_err = err;
    for (int i = 0; i < nw; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = base + 32'(i) * 32'h0101_0101;
      rsp_last  = last_mask[i];
      guard = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = rsp_valid && rsp_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!hs && !abort && guard < 1000);
      if (abort) begin
        sending = 1'b0;
        return;
      end
      if (!hs) begin
        total++;
        bad++;
        $display("FAIL rsp_handshake: got timeout want beat %0d accepted", i);
        break;
      end
    end
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    sending = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || sending) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int base_hs;
    int guard;
    int busy;
    n_rst = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'h0;
    rsp_len = 7'd0;
    rsp_err = 1'b0;
    rsp_last = 1'b0;
    upd_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_ren", 64'(fifo_ren), 64'(0));
    check("rst_rsp_ready", 64'(rsp_ready), 64'(0));
    check("rst_flit_valid", 64'(flit_valid), 64'(0));
    check("rst_flit_last", 64'(flit_last), 64'(0));
    check("rst_flit_data", 64'(flit_data), 64'(0));
    check("rst_len_err", 64'(len_err), 64'(0));
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // basic len=2 packet
    r0 = ren_cnt;
    push_id(5'h0A);
    send(7'd2, 1'b0, 32'h250C_0800, 32'hDEAD_0001, 8'b10, 2);
    wait_drain("drain_basic");
    check("ren_once", 64'(ren_cnt - r0), 64'(1));
    check("len_err_basic", 64'(len_err), 64'(0));

    // response waiting with no requestor ID must not start a packet
    rsp_valid = 1'b1;
    rsp_len = 7'd1;
    rsp_data = 32'h1234_5678;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flit_valid || rsp_ready || fifo_ren) busy++;
    end
    @(posedge clk);
    #1;
    check("empty_wait_idle", 64'(busy), 64'(0));
    push_id(5'h05);
    send(7'd1, 1'b0, 32'h228C_0400, 32'h1234_5678, 8'b1, 1);
    wait_drain("drain_empty_wait");

    // random backpressure, len=5, err=1
    rand_ready = 1'b1;
    base_hs = hs_cnt;
    push_id(5'h11);
    send(7'd5, 1'b1, 32'h288E_1400, 32'hA5A5_0000, 8'b1_0000, 5);
    wait_drain("drain_stall");
    rand_ready = 1'b0;
    check("stall_flit_count", 64'(hs_cnt - base_hs), 64'(7));
    check("len_err_stall", 64'(len_err), 64'(0));

    // early rsp_last on beat 1 of 3
    push_id(5'h1F);
    send(7'd3, 1'b0, 32'h2F8C_0C00, 32'h0BAD_0000, 8'b010, 3);
    wait_drain("drain_early_last");
    check("len_err_early_last", 64'(len_err), 64'(1));

    // zero length forced to one word; len_err stays set
    push_id(5'h00);
    send(7'd0, 1'b0, 32'h200C_0400, 32'h0000_FFFF, 8'b1, 1);
    wait_drain("drain_len0");
    check("len_err_sticky", 64'(len_err), 64'(1));

    // reset in the middle of the data phase
    r0 = ren_cnt;
    push_id(5'h07);
    push_id(5'h0B);
    base_hs = hs_cnt;
    abort = 1'b0;
    fork
      send(7'd4, 1'b0, 32'h238C_1000, 32'h7777_0000, 8'b1000, 4);
    join_none
    guard = 0;
    while (hs_cnt < base_hs + 2 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_beat2", 64'(hs_cnt - base_hs), 64'(2));
    n_rst = 1'b0;
    abort = 1'b1;
    rsp_valid = 1'b0;
    rsp_last = 1'b0;
    #1;
    check("midrst_outputs", 64'({fifo_ren, rsp_ready, flit_valid, flit_last, len_err}), 64'(0));
    check("midrst_flit_data", 64'(flit_data), 64'(0));
    guard = 0;
    while (sending && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    abort = 1'b0;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("len_err_after_rst", 64'(len_err), 64'(0));
    send(7'd2, 1'b0, 32'h258C_0800, 32'h0C0C_0000, 8'b10, 2);
    wait_drain("drain_after_rst");
    check("ren_after_rst", 64'(ren_cnt - r0), 64'(2));
    check("fifo_drained", 64'(fifo_empty), 64'(1));
    check("len_err_clean", 64'(len_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
